// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared sizing helpers for the FIFO read-side drain engine.
// Provides buffer depth from read latency and a non-power-of-two pointer wrap.
package fifo_rd_pkg;

    localparam int MAX_RD_LATENCY = 2;

    // One slot per in-flight read plus two so a pop and a push can overlap
    // without starving the issue logic.
    function automatic int buf_depth(input int rd_latency);
        return rd_latency + 2;
    endfunction

    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port plus downstream valid/ready stream.
// master = drain engine side, slave = FIFO / downstream consumer side.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_r_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_r_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_r_en, m_valid, m_data
    );
endinterface

// File: rtl/rd_skid_buf.sv
// rd_skid_buf: circular register buffer of DEPTH words (any depth >= 2).
// Ports: clk/rst, i_push/i_data write, i_pop read, o_occ count, o_head_data.
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 3,
    localparam int PW        = $clog2(DEPTH),
    localparam int OW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [OW-1:0]         o_occ,
    output logic [DATA_WIDTH-1:0] o_head_data
);
    localparam logic [OW-1:0] ONE  = OW'(1);
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [OW-1:0]         r_occ;
    logic                  w_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return PW'(ptr_inc(int'(p), DEPTH));
    endfunction

    assign w_pop = i_pop & (r_occ != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_data;
                r_tail        <= nxt(r_tail);
            end
            if (w_pop) r_head <= nxt(r_head);
            if (i_push && !w_pop)      r_occ <= r_occ + ONE;
            else if (!i_push && w_pop) r_occ <= r_occ - ONE;
        end
    end

    assign o_occ       = r_occ;
    assign o_head_data = r_mem[r_head];

    // The issuer reserves a slot for every in-flight read.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) i_push |-> (r_occ != FULL)
    );

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains an async FIFO read port into a valid/ready stream.
// Ports: clk/rst, en (allow reads), bus (FIFO + stream), word_count, idle.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    fifo_stream_reader_if.master bus,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic                 idle
);
    localparam int BUF_DEPTH = buf_depth(RD_LATENCY);
    localparam int OW        = $clog2(BUF_DEPTH + 1);
    localparam int CW        = OW + 1;

    if (RD_LATENCY < 0 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_lat
        $error("RD_LATENCY out of range");
    end

    logic [OW-1:0]        w_occ;
    logic [OW-1:0]        w_inflight_cnt;
    logic [CW-1:0]        w_credit_used;
    logic                 w_r_en;
    logic                 w_push;
    logic                 w_pop;
    logic [CNT_WIDTH-1:0] r_word_count;

    // Credit uses only registered state, so m_ready never reaches fifo_r_en.
    assign w_credit_used = {1'b0, w_occ} + {1'b0, w_inflight_cnt};
    assign w_r_en = ~rst & en & ~bus.fifo_empty
                  & (w_credit_used < CW'(BUF_DEPTH));
    assign bus.fifo_r_en = w_r_en;

    if (RD_LATENCY == 0) begin : g_no_pipe
        assign w_push         = w_r_en;
        assign w_inflight_cnt = '0;
    end else begin : g_pipe
        logic [RD_LATENCY-1:0] r_inflight;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_inflight <= '0;
            end else begin
                r_inflight[0] <= w_r_en;
                for (int i = 1; i < RD_LATENCY; i++)
                    r_inflight[i] <= r_inflight[i-1];
            end
        end

        always_comb begin
            w_inflight_cnt = '0;
            for (int i = 0; i < RD_LATENCY; i++)
                w_inflight_cnt = w_inflight_cnt + OW'(r_inflight[i]);
        end

        assign w_push = r_inflight[RD_LATENCY-1];
    end

    rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_data      (bus.fifo_data),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_head_data (bus.m_data)
    );

    assign bus.m_valid = (w_occ != '0);
    assign w_pop       = bus.m_valid & bus.m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_word_count <= '0;
        else if (w_pop) r_word_count <= r_word_count + CNT_WIDTH'(1);
    end

    assign word_count = r_word_count;
    assign idle       = (w_occ == '0) & (w_inflight_cnt == '0);

endmodule
